serial_adder_seq: RTL and testbench
===================================

// Module: serial_adder_seq
// PURPOSE
//   Parametrised bit-serial add/subtract unit: WIDTH-bit operands processed LSB-first,
//   one bit per clock, through one full-adder cell and a registered carry.
//   start/busy/done handshake; registered result held until the next accepted start.
//   Area-lean arithmetic stage for datapaths where one result per WIDTH+2 cycles is enough.
// PARAMETERS
//   WIDTH   8   operand/result width in bits, >= 1
//   CNT_W   $clog2(WIDTH+1)   localparam, bit-counter width; not overridable
// PORTS
//   clk       in   1      clock; all state updates on rising edge
//   rst_n     in   1      asynchronous active-low reset
//   start     in   1      request; sampled only in IDLE
//   a         in   WIDTH  operand A; captured when start is accepted
//   b         in   WIDTH  operand B; captured when start is accepted
//   c_in      in   1      carry-in for add; ignored when sub=1
//   sub       in   1      0: a+b+c_in; 1: a-b, computed as a+~b+1; captured with operands
//   busy      out  1      1 while in RUN
//   done      out  1      one-cycle pulse; result valid
//   sum       out  WIDTH  registered result
//   c_out     out  1      carry out of MSB; for sub, 1 = no borrow
//   overflow  out  1      signed overflow: carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE; busy, done, sum, c_out, overflow = 0;
//     internal operand and shift registers, carry and counter cleared.
//     Reset during RUN aborts the operation; no done pulse.
//   FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: start=1 at edge E0: latch a, b^{WIDTH{sub}}, carry <= sub ? 1 : c_in, cnt <= 0 -> RUN.
//     start=0: stay in IDLE.
//   RUN (busy=1): each edge: bit = a[cnt]^bx[cnt]^carry; carry <= maj(a[cnt],bx[cnt],carry);
//     bit shifted into internal shift register from MSB side; cnt++.
//     Carry into the MSB cell is saved when cnt=WIDTH-1, for overflow.
//     After the edge processing bit WIDTH-1 (edge E0+WIDTH) -> DONE.
//     At that same edge load sum, c_out and overflow in parallel.
//   DONE: done=1 for exactly one cycle; busy=0 -> IDLE unconditionally.
//   Latency: done high in the cycle after edge E0+WIDTH. Min start-to-start spacing is WIDTH+2 cycles.
//   start ignored in RUN and DONE; no queueing, no error flag.
//   Operand inputs a/b/c_in/sub may change freely after acceptance; no effect on the running op.
//   sum/c_out/overflow hold the previous result through IDLE and RUN.
//     They change only at the edge entering DONE, or on reset.
//   Arithmetic is modulo 2^WIDTH; c_out is the (WIDTH+1)th bit.
//   WIDTH=1: single full-adder cell; overflow = c_in_to_msb ^ c_out still defined.
// TESTING
//   WIDTH=8, add 8'h0F+8'h01, c_in=0 -> sum=8'h10, c_out=0, ovf=0.
//     done pulses exactly 8 cycles after the start edge, one cycle wide; busy high for 8 cycles.
//   add 8'hFF+8'h01, c_in=1 -> sum=8'h01, c_out=1, ovf=0.
//     add 8'h7F+8'h01 -> sum=8'h80, c_out=0, ovf=1.
//   sub 8'h05-8'h07 (c_in=1 ignored) -> sum=8'hFE, c_out=0, ovf=0.
//     sub 8'h80-8'h01 -> sum=8'h7F, c_out=1, ovf=1.
//   Re-pulse start and change a/b during RUN and DONE -> ignored; result per original operands.
//     sum holds the prior result while busy=1.
//   rst_n low at cnt=4 of a RUN -> all outputs 0 asynchronously, no done pulse.
//     After release, next start computes 8'h12+8'h34=8'h46 correctly.
//   WIDTH=1 override: exhaustive 8 combos of a/b/c_in with sub=0 -> full-adder truth table.
//     done pulses 1 cycle after the start edge.

Source files
------------

// File: rtl/serial_adder_seq.sv
// Bit-serial add/subtract: one full-adder cell plus a registered carry, LSB first,
// with a start/busy/done handshake and a result held until the next accepted start.
module serial_adder_seq #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             overflow
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] bx_q;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_nx;
    logic             carry;
    logic             bit_nx;
    logic             carry_nx;
    logic             last_bit;
    logic [CNT_W-1:0] cnt;

    // Operands shift right each RUN cycle, so the active bit is always at index 0.
    assign bit_nx   = a_q[0] ^ bx_q[0] ^ carry;
    assign carry_nx = (a_q[0] & bx_q[0]) | (a_q[0] & carry) | (bx_q[0] & carry);
    assign shreg_nx = (shreg >> 1) | (WIDTH'(bit_nx) << (WIDTH - 1));
    assign last_bit = (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Datapath and registered outputs; carry held at the MSB step is the carry into the MSB.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q      <= '0;
            bx_q     <= '0;
            shreg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            c_out    <= 1'b0;
            overflow <= 1'b0;
        end else begin
            busy <= (state_nx == RUN);
            done <= (state_nx == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        bx_q  <= b ^ {WIDTH{sub}};
                        carry <= sub ? 1'b1 : c_in;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    a_q   <= a_q >> 1;
                    bx_q  <= bx_q >> 1;
                    carry <= carry_nx;
                    shreg <= shreg_nx;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_bit) begin
                        sum      <= shreg_nx;
                        c_out    <= carry_nx;
                        overflow <= carry ^ carry_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_seq.sv
// Bench for serial_adder_seq: WIDTH=8 vector table with a result scoreboard,
// handshake/abort corner sequences, and an exhaustive WIDTH=1 full-adder sweep.
module tb_serial_adder_seq;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, cin8, sub8;
    logic [7:0] a8, b8;
    logic       busy8, done8, cout8, ovf8;
    logic [7:0] sum8;
    logic       start1, cin1;
    logic [0:0] a1, b1, sum1;
    logic       busy1, done1, cout1, ovf1;

    int         n_cmp = 0;
    int         n_bad = 0;
    vec_t       q8[$];
    logic [7:0] last_sum;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c_in(cin8), .sub(sub8),
        .busy(busy8), .done(done8), .sum(sum8), .c_out(cout8), .overflow(ovf8)
    );

    serial_adder_seq #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1), .c_in(cin1), .sub(1'b0),
        .busy(busy1), .done(done1), .sum(sum1), .c_out(cout1), .overflow(ovf1)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: plain wide addition with the operand inverted for subtract.
    function automatic vec_t model(input logic [7:0] a, input logic [7:0] b,
                                   input logic cin, input logic sub);
        vec_t       v;
        logic [7:0] bx;
        logic [8:0] s;
        bx     = sub ? ~b : b;
        s      = {1'b0, a} + {1'b0, bx} + 9'(sub ? 1'b1 : cin);
        v.a    = a;
        v.b    = b;
        v.cin  = cin;
        v.sub  = sub;
        v.sum  = s[7:0];
        v.cout = s[8];
        v.ovf  = (a[7] == bx[7]) && (s[7] != a[7]);
        return v;
    endfunction

    // Scoreboard: every done pulse must match the oldest outstanding request.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && done8 === 1'b1) begin
            if (q8.size() == 0) begin
                check("unexpected_done", 32'(done8), 32'd0);
            end else begin
                vec_t e;
                e = q8.pop_front();
                check("sb_sum", 32'(sum8), 32'(e.sum));
                check("sb_cout", 32'(cout8), 32'(e.cout));
                check("sb_ovf", 32'(ovf8), 32'(e.ovf));
            end
        end
    end

    task automatic run8(input vec_t v, input bit disturb);
        int lat;
        int busy_n;
        bit hold_ok;
        @(negedge clk);
        a8 = v.a; b8 = v.b; cin8 = v.cin; sub8 = v.sub; start8 = 1'b1;
        q8.push_back(v);
        @(posedge clk); #1;
        start8 = 1'b0;
        if (disturb) begin
            a8 = ~v.a; b8 = 8'h5A; cin8 = ~v.cin; sub8 = ~v.sub;
        end
        lat = 0; busy_n = 0; hold_ok = 1'b1;
        while (done8 !== 1'b1 && lat < 40) begin
            if (busy8 === 1'b1) busy_n++;
            if (sum8 !== last_sum) hold_ok = 1'b0;
            if (disturb && lat == 3) start8 = 1'b1;
            if (disturb && lat == 4) start8 = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check("latency", 32'(lat), 32'd8);
        check("busy_cycles", 32'(busy_n), 32'd8);
        check("sum_hold", 32'(hold_ok), 32'd1);
        if (disturb) start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        check("done_width", 32'(done8), 32'd0);
        last_sum = v.sum;
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rv;
        logic [1:0] fa;

        rst_n = 1'b0; start8 = 1'b0; a8 = '0; b8 = '0; cin8 = 1'b0; sub8 = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        last_sum = 8'h00;

        tbl.push_back('{8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, 1'b0});
        tbl.push_back('{8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0});
        tbl.push_back('{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1});
        tbl.push_back('{8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0});
        tbl.push_back('{8'h00, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0});
        tbl.push_back('{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1});
        for (int i = 0; i < 6; i++) begin
            tbl.push_back(model(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom)));
        end

        repeat (3) @(posedge clk);
        #1;
        check("rst_sum", 32'(sum8), 32'd0);
        check("rst_cout", 32'(cout8), 32'd0);
        check("rst_ovf", 32'(ovf8), 32'd0);
        check("rst_busy", 32'(busy8), 32'd0);
        check("rst_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run8(tbl[i], 1'b0);
        end

        // Re-pulsed start and changing operands during RUN/DONE must not disturb the op.
        run8('{8'h3C, 8'h21, 1'b1, 1'b0, 8'h5E, 1'b0, 1'b0}, 1'b1);
        repeat (12) @(posedge clk);
        run8('{8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1}, 1'b0);

        // Asynchronous reset in the middle of RUN aborts with no done pulse.
        @(negedge clk);
        a8 = 8'h55; b8 = 8'h22; cin8 = 1'b0; sub8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("abort_sum", 32'(sum8), 32'd0);
        check("abort_cout", 32'(cout8), 32'd0);
        check("abort_ovf", 32'(ovf8), 32'd0);
        check("abort_busy", 32'(busy8), 32'd0);
        check("abort_done", 32'(done8), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        last_sum = 8'h00;
        repeat (12) @(posedge clk);
        run8('{8'h12, 8'h34, 1'b0, 1'b0, 8'h46, 1'b0, 1'b0}, 1'b0);

        // WIDTH=1: exhaustive full-adder truth table, done one cycle after start edge.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            a1 = 1'(i >> 2); b1 = 1'(i >> 1); cin1 = 1'(i); start1 = 1'b1;
            fa = 2'(a1) + 2'(b1) + 2'(cin1);
            @(posedge clk); #1;
            start1 = 1'b0;
            check("w1_early_done", 32'(done1), 32'd0);
            @(posedge clk); #1;
            check("w1_done", 32'(done1), 32'd1);
            check("w1_sum", 32'(sum1), 32'(fa[0]));
            check("w1_cout", 32'(cout1), 32'(fa[1]));
            check("w1_ovf", 32'(ovf1), 32'(cin1 ^ fa[1]));
            @(posedge clk); #1;
            check("w1_done_width", 32'(done1), 32'd0);
        end

        repeat (4) @(posedge clk);
        check("sb_drained", 32'(q8.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
